// File: rtl/msrv32_fetch_pkg.sv
// Shared types and constants for the msrv32 instruction fetch stage.
package msrv32_fetch_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          DEFAULT_DEPTH = 2;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clears the byte offset so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Prefetch buffer holding returned instruction words tagged with their PC.
// A clear wins over push/pop in the same cycle.
module msrv32_fetch_fifo
  import msrv32_fetch_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          rst_b,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  pop_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push & ~clear;
  assign do_pop   = pop & ~empty & ~clear;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The parent limits requests so a push can never find the buffer full.
  a_no_overflow: assert property (@(posedge clk_sys) disable iff (!rst_b)
    !(push && !clear && full));

endmodule

// File: rtl/msrv32_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues requests on the
// req/gnt/rvalid memory port, buffers returned words and presents one per
// cycle to the instruction mux. flush_out marks an empty output slot.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_BOOT  | first cycle after reset release, no request yet
// S_RUN   | normal fetch, requests issued while capacity remains
// S_FLUSH | redirect taken with requests in flight, dropping stale data
module msrv32_fetch_unit
  import msrv32_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = DEFAULT_DEPTH
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic [31:0] ms_riscv32_mp_instr_out,
  output logic [31:0] pc_out,
  output logic        flush_out
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_after_rsp;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_clear;
  fetch_entry_t  fifo_head;
  fetch_entry_t  resp_entry;
  logic          grant;
  logic          accept;
  logic          bypass;

  // Capacity is shared between buffered words and requests still in flight,
  // so the buffer can absorb every response even while the output stalls.
  assign imem_req_out = (state == S_RUN) && !redirect_in &&
                        ((32'(fifo_count) + 32'(outstanding)) < 32'(DEPTH));
  assign imem_addr_out = fetch_pc;

  assign grant                 = imem_req_out & imem_gnt_in;
  assign outstanding_after_rsp = outstanding - CW'(imem_rvalid_in);
  assign redirect_target       = word_align(redirect_pc_in);

  // A response is kept only when nothing stale remains and no redirect is
  // discarding the pipeline in the same cycle.
  assign accept     = imem_rvalid_in & ~redirect_in & (discard == '0);
  assign bypass     = accept & ~stall_in & fifo_empty;
  assign fifo_push  = accept & ~bypass;
  assign fifo_pop   = ~redirect_in & ~stall_in & ~fifo_empty;
  assign fifo_clear = redirect_in;
  assign resp_entry = '{pc: resp_pc, instr: imem_rdata_in};

  msrv32_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_sys  (ms_riscv32_mp_clk_in),
    .rst_b    (ms_riscv32_mp_rst_in),
    .clear    (fifo_clear),
    .push     (fifo_push),
    .push_data(resp_entry),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // State register.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) state <= S_BOOT;
    else                       state <= state_nxt;
  end

  // Next-state logic; a redirect overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      S_FLUSH: begin
        if (discard == '0) begin
          state_nxt = S_RUN;
        end else if (imem_rvalid_in && (discard == CW'(1))) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
    if (redirect_in) begin
      state_nxt = (outstanding_after_rsp != '0) ? S_FLUSH : S_RUN;
    end
  end

  // Fetch/response PCs and the in-flight and stale-response counters.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      fetch_pc    <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_after_rsp + CW'(grant);
      if (redirect_in) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        discard  <= outstanding_after_rsp;
      end else begin
        if (grant)  fetch_pc <= fetch_pc + 32'd4;
        if (accept) resp_pc  <= resp_pc + 32'd4;
        if (imem_rvalid_in && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  // Output slot: oldest buffered word first, otherwise a bypassed response,
  // otherwise an empty slot that the mux turns into a NOP.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      ms_riscv32_mp_instr_out <= NOP_INSTR;
      pc_out                  <= BOOT_ADDR;
      flush_out               <= 1'b1;
    end else if (redirect_in) begin
      ms_riscv32_mp_instr_out <= NOP_INSTR;
      flush_out               <= 1'b1;
    end else if (!stall_in) begin
      if (!fifo_empty) begin
        ms_riscv32_mp_instr_out <= fifo_head.instr;
        pc_out                  <= fifo_head.pc;
        flush_out               <= 1'b0;
      end else if (bypass) begin
        ms_riscv32_mp_instr_out <= resp_entry.instr;
        pc_out                  <= resp_entry.pc;
        flush_out               <= 1'b0;
      end else begin
        ms_riscv32_mp_instr_out <= NOP_INSTR;
        flush_out               <= 1'b1;
      end
    end
  end

  a_capacity: assert property (@(posedge ms_riscv32_mp_clk_in)
    disable iff (!ms_riscv32_mp_rst_in)
    (32'(fifo_count) + 32'(outstanding)) <= 32'(DEPTH));

  a_rsp_expected: assert property (@(posedge ms_riscv32_mp_clk_in)
    disable iff (!ms_riscv32_mp_rst_in)
    imem_rvalid_in |-> (outstanding != '0));

  a_push_room: assert property (@(posedge ms_riscv32_mp_clk_in)
    disable iff (!ms_riscv32_mp_rst_in)
    fifo_push |-> !fifo_full);

endmodule

// File: doc/msrv32_fetch_unit.md
# msrv32_fetch_unit

Instruction fetch stage of the msrv32 pipeline, directly upstream of the instruction mux. It owns the fetch PC and drives a request/grant/response-valid instruction-memory port. Returned words are buffered and presented one per cycle as `ms_riscv32_mp_instr_out` with its PC. `flush_out` feeds the mux's `flush_in`, so every bubble, redirect or stall-free empty slot becomes a NOP (32'h00000013) downstream.

## Interface
- `BOOT_ADDR`, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `DEPTH`, 2: prefetch FIFO entries; also the maximum number of outstanding plus buffered words.
- `ms_riscv32_mp_clk_in`  in  1  single clock, rising edge.
- `ms_riscv32_mp_rst_in`  in  1  asynchronous, active-low reset.
- `imem_req_out`  out  1  fetch request valid.
- `imem_addr_out`  out  32  word-aligned fetch address.
- `imem_gnt_in`  in  1  request accepted this cycle; valid only while `imem_req_out`=1.
- `imem_rvalid_in`  in  1  response data valid; responses come in order, one per grant, at least 1 cycle after their grant.
- `imem_rdata_in`  in  32  instruction word.
- `redirect_in`  in  1  branch/jump/trap taken, from later stage.
- `redirect_pc_in`  in  32  redirect target; bits [1:0] are forced to 0 internally.
- `stall_in`  in  1  downstream hold.
- `ms_riscv32_mp_instr_out`  out  32  instruction to the mux.
- `pc_out`  out  32  PC of `ms_riscv32_mp_instr_out`.
- `flush_out`  out  1  1 = output slot empty or invalid; the mux substitutes a NOP.

## Operation
- **States:**
  - S_BOOT: first cycle after reset release → S_RUN.
  - S_RUN: normal fetch.
  - S_FLUSH: discarding stale responses.
- **Counters:** `outstanding` counts granted requests without a response; `discard` counts stale responses still to drop. Both are 0..DEPTH wide.
- **Request:** `imem_req_out` = S_RUN & !`redirect_in` & (`fifo_count` + `outstanding` < DEPTH). `imem_addr_out` = `fetch_pc`.
- **Grant:** on `imem_req_out` & `imem_gnt_in`, `fetch_pc` += 4 (wraps modulo 2^32) and `outstanding`++.
- **Response:** on `imem_rvalid_in`, `outstanding`--.
  - If `discard` > 0: `discard`--, data dropped; reaching 0 in S_FLUSH → S_RUN.
  - Else: word is tagged with `resp_pc`, then `resp_pc` += 4. It goes to the output slot if bypass applies, otherwise it is pushed into the FIFO.
- **Output slot** (registers `ms_riscv32_mp_instr_out`, `pc_out`, `flush_out`), when `stall_in`=0:
  - FIFO non-empty: pop the head into the slot, `flush_out`=0.
  - FIFO empty and accepted response present: bypass it into the slot, `flush_out`=0.
  - Otherwise: `flush_out`=1, instr = NOP.
  - When `stall_in`=1, the slot holds and the FIFO keeps filling.
- **Redirect** (priority over everything, including `stall_in`):
  - `fetch_pc` and `resp_pc` load the aligned `redirect_pc_in`.
  - FIFO is cleared; the output slot gets `flush_out`=1 and NOP.
  - `discard` is loaded with `outstanding` minus that cycle's `imem_rvalid_in`; any response arriving in the redirect cycle is dropped.
  - Next state is S_FLUSH if `discard` ≠ 0, else S_RUN.
- **Redirect in S_FLUSH:** same update, so `discard` is reloaded from the current `outstanding`.
- **Invariant:** `fifo_count` + `outstanding` ≤ DEPTH, so the FIFO never overflows. A push while the FIFO is full is a design error; flag it with an assertion.

## Timing
- **Reset values** (asynchronous assert, synchronous release):
  - `imem_req_out`=0, `imem_addr_out`=BOOT_ADDR.
  - `ms_riscv32_mp_instr_out`=32'h00000013, `pc_out`=BOOT_ADDR, `flush_out`=1.
  - State = S_BOOT; FIFO and all counters 0.
- **Boot:** the first request is asserted 1 cycle after release, with address BOOT_ADDR.
- **Fetch latency:** `imem_rvalid_in` in cycle k → valid output in cycle k+1 via bypass. If the FIFO is non-empty, the word instead waits behind older entries.
- **Redirect latency:** redirect in cycle N → `flush_out`=1 from cycle N+1.
  - With no outstanding requests: a request to the target is issued in N+1.
  - Otherwise: the request is issued 1 cycle after the last stale response.
- **Throughput:** with a single-cycle grant and 1-cycle response, the unit sustains 1 instruction per cycle when DEPTH ≥ 2.
- **Reset mid-operation:** all state is lost. In-flight responses after reset release are a system error; the memory is reset on the same reset.

## Structure
- **Package `msrv32_fetch_pkg`:**
  - `NOP_INSTR` = 32'h00000013.
  - State typedef (S_BOOT, S_RUN, S_FLUSH).
  - Default DEPTH.
- **Sub-module `msrv32_fetch_fifo`:**
  - DEPTH-entry synchronous FIFO of {pc[31:0], instr[31:0]}.
  - Ports: push, pop, synchronous clear, count, empty, full.
  - Same clock and reset as the parent.

## Test plan
- **Reset/boot:** assert reset, release → `flush_out`=1 and instr=0x13 during reset; first `imem_req_out` with addr 0x0 one cycle after release.
- **Streaming:** memory with grant always high and 1-cycle response returning addr^0xA5A5_0000 → output PCs 0x0, 0x4, 0x8… on consecutive cycles, each with matching data and `flush_out`=0.
- **Redirect with 2 outstanding:** 2 requests in flight, `redirect_in`=1 with target 0x0000_0102 → both stale responses dropped; next request addr 0x0000_0100; `flush_out`=1 until the 0x100 word is output.
- **Stall:** hold `stall_in`=1 for 5 cycles while streaming → output frozen; requests stop once FIFO count + outstanding = 2; no word lost or duplicated after release.
- **Same-cycle events:** `imem_rvalid_in` and `redirect_in` in the same cycle → response dropped and `discard` equals the remaining outstanding count.
- **Wrap:** redirect to 0xFFFF_FFFC → next fetch addr 0x0000_0000; `pc_out` sequence 0xFFFF_FFFC, 0x0.
